fft_seq_ctrl: RTL and testbench

//   Sequences an in-place radix-2 DIT FFT over the 512x16 dual-port BRAM pair (re/im, shared addresses).

---
 rtl/fft_pkg.sv | 20 ++
 rtl/fft_addr_gen.sv | 46 ++++
 rtl/fft_seq_ctrl.sv | 171 +++++++++++++++++
 tb/tb_fft_seq_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and sizing constants for the in-place radix-2 FFT sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fft_pkg;

    localparam int LOG2N  = 9;
    localparam int N      = 1 << LOG2N;
    localparam int HALF_N = N / 2;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        WAIT,
        WR_A,
        WR_B,
        DONE
    } state_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Maps (stage, butterfly index) to the two operand addresses and the twiddle ROM index.
// Latency: purely combinational; the caller registers the results.
// Backpressure: none, output follows input every cycle.
//
// Ports:
//   i_stage  current stage s (0..LOG2N-1)
//   i_k      butterfly index within the stage
//   o_a      address of the upper operand
//   o_b      address of the lower operand (o_a + 2^s)
//   o_tw     twiddle index into the half-length ROM
module fft_addr_gen #(
    parameter int LOG2N = 9
) (
    input  logic [3:0]       i_stage,
    input  logic [LOG2N-2:0] i_k,
    output logic [LOG2N-1:0] o_a,
    output logic [LOG2N-1:0] o_b,
    output logic [LOG2N-2:0] o_tw
);
    localparam int AW = LOG2N;

    logic [AW-1:0] k_ext;
    logic [AW-1:0] half;
    logic [AW-1:0] j;
    logic [AW-1:0] grp;
    logic [AW-1:0] a_v;
    logic [AW-1:0] tw_full;
    logic [3:0]    tw_sh;

    always_comb begin
        k_ext   = {1'b0, i_k};
        half    = AW'(1) << i_stage;
        // Position inside the group and group number; groups are 2*half apart.
        j       = k_ext & (half - AW'(1));
        grp     = k_ext >> i_stage;
        a_v     = (grp << (i_stage + 4'd1)) | j;
        // Twiddle W_N^(j * N / 2^(s+1)); the top bit is always zero for legal stages.
        tw_sh   = 4'(LOG2N - 1) - i_stage;
        tw_full = j << tw_sh;
    end

    assign o_a  = a_v;
    assign o_b  = a_v + half;
    assign o_tw = tw_full[AW-2:0];

endmodule

// File: rtl/fft_seq_ctrl.sv
// Sequences an in-place radix-2 DIT FFT over a re/im BRAM pair and an external butterfly.
// Latency: 4+BF_LAT cycles per butterfly, LOG2N*2^(LOG2N-1) butterflies, then a one-cycle done pulse.
// Backpressure: none; i_start is only honoured in IDLE and ignored while busy.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start               run request, sampled in IDLE only
//   o_busy / o_done       state != IDLE / one-cycle pulse after the final write
//   o_rd_en, o_rd_addr    BRAM read port (1-cycle read latency)
//   o_wr_en, o_wr_addr    BRAM write port
//   o_wr_sel              write data select: 0 = A', 1 = B'
//   o_cap_a, o_cap_b      BRAM read data holds operand A / B this cycle
//   o_tw_addr             twiddle ROM index, held for the whole butterfly
//   o_stage               current stage, for per-stage scaling
module fft_seq_ctrl #(
    parameter int LOG2N  = 9,
    parameter int BF_LAT = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_rd_en,
    output logic [LOG2N-1:0] o_rd_addr,
    output logic             o_wr_en,
    output logic [LOG2N-1:0] o_wr_addr,
    output logic             o_wr_sel,
    output logic             o_cap_a,
    output logic             o_cap_b,
    output logic [LOG2N-2:0] o_tw_addr,
    output logic [3:0]       o_stage
);
    import fft_pkg::*;

    localparam int              KW     = LOG2N - 1;
    localparam int              WW     = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
    localparam logic [KW-1:0]   K_LAST = {KW{1'b1}};
    localparam logic [3:0]      S_LAST = 4'(LOG2N - 1);
    localparam logic [WW-1:0]   W_LOAD = WW'(BF_LAT - 1);

    state_t           state_q, state_d;
    logic [3:0]       stage_q, stage_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic             ld_addr;
    logic [LOG2N-1:0] a_q, b_q, a_nxt, b_nxt;
    logic [KW-1:0]    tw_q, tw_nxt;

    // Addresses are computed from the next (stage, k) so they are already
    // registered when the butterfly's RD_A cycle begins.
    fft_addr_gen #(
        .LOG2N (LOG2N)
    ) u_addr_gen (
        .i_stage (stage_d),
        .i_k     (k_d),
        .o_a     (a_nxt),
        .o_b     (b_nxt),
        .o_tw    (tw_nxt)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            stage_q <= '0;
            k_q     <= '0;
            wait_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tw_q    <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            k_q     <= k_d;
            wait_q  <= wait_d;
            if (ld_addr) begin
                a_q  <= a_nxt;
                b_q  <= b_nxt;
                tw_q <= tw_nxt;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        k_d     = k_q;
        wait_d  = wait_q;
        ld_addr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = RD_A;
                    stage_d = '0;
                    k_d     = '0;
                    ld_addr = 1'b1;
                end
            end
            RD_A: state_d = RD_B;
            RD_B: begin
                state_d = WAIT;
                wait_d  = W_LOAD;
            end
            WAIT: begin
                if (wait_q == '0) begin
                    state_d = WR_A;
                end else begin
                    wait_d = wait_q - WW'(1);
                end
            end
            WR_A: state_d = WR_B;
            WR_B: begin
                if (k_q != K_LAST) begin
                    k_d     = k_q + KW'(1);
                    state_d = RD_A;
                    ld_addr = 1'b1;
                end else if (stage_q != S_LAST) begin
                    stage_d = stage_q + 4'd1;
                    k_d     = '0;
                    state_d = RD_A;
                    ld_addr = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_busy    = (state_q != IDLE);
        o_done    = (state_q == DONE);
        o_rd_en   = 1'b0;
        o_rd_addr = '0;
        o_wr_en   = 1'b0;
        o_wr_addr = '0;
        o_wr_sel  = 1'b0;
        o_cap_a   = 1'b0;
        o_cap_b   = 1'b0;
        case (state_q)
            RD_A: begin
                o_rd_en   = 1'b1;
                o_rd_addr = a_q;
            end
            RD_B: begin
                o_rd_en   = 1'b1;
                o_rd_addr = b_q;
                o_cap_a   = 1'b1;   // A's data returns one cycle after RD_A
            end
            WAIT: begin
                // Counter still holds its load value only in the first WAIT cycle.
                o_cap_b = (wait_q == W_LOAD);
            end
            WR_A: begin
                o_wr_en   = 1'b1;
                o_wr_addr = a_q;
            end
            WR_B: begin
                o_wr_en   = 1'b1;
                o_wr_addr = b_q;
                o_wr_sel  = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_tw_addr = tw_q;
    assign o_stage   = stage_q;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
module tb_fft_seq_ctrl;
    localparam int N  = 512;
    localparam int NB = 2304;
    localparam int P  = 7681;   // prime, P-1 = 15*512, so a 512th root of unity exists

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [3];
    logic       start [3];
    logic       busy [3], done [3], rd_en [3], wr_en [3], wr_sel [3], cap_a [3], cap_b [3];
    logic [8:0] rd_addr [3], wr_addr [3];
    logic [7:0] tw [3];
    logic [3:0] stage [3];

    fft_seq_ctrl #(.LOG2N(9), .BF_LAT(2)) u_dut0 (
        .i_clk(clk), .i_rst(rst[0]), .i_start(start[0]), .o_busy(busy[0]), .o_done(done[0]),
        .o_rd_en(rd_en[0]), .o_rd_addr(rd_addr[0]), .o_wr_en(wr_en[0]), .o_wr_addr(wr_addr[0]),
        .o_wr_sel(wr_sel[0]), .o_cap_a(cap_a[0]), .o_cap_b(cap_b[0]), .o_tw_addr(tw[0]), .o_stage(stage[0]));
    fft_seq_ctrl #(.LOG2N(9), .BF_LAT(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst[1]), .i_start(start[1]), .o_busy(busy[1]), .o_done(done[1]),
        .o_rd_en(rd_en[1]), .o_rd_addr(rd_addr[1]), .o_wr_en(wr_en[1]), .o_wr_addr(wr_addr[1]),
        .o_wr_sel(wr_sel[1]), .o_cap_a(cap_a[1]), .o_cap_b(cap_b[1]), .o_tw_addr(tw[1]), .o_stage(stage[1]));
    fft_seq_ctrl #(.LOG2N(9), .BF_LAT(5)) u_dut2 (
        .i_clk(clk), .i_rst(rst[2]), .i_start(start[2]), .o_busy(busy[2]), .o_done(done[2]),
        .o_rd_en(rd_en[2]), .o_rd_addr(rd_addr[2]), .o_wr_en(wr_en[2]), .o_wr_addr(wr_addr[2]),
        .o_wr_sel(wr_sel[2]), .o_cap_a(cap_a[2]), .o_cap_b(cap_b[2]), .o_tw_addr(tw[2]), .o_stage(stage[2]));

    int checks   = 0;
    int failures = 0;

    // Reference tables
    int ba [NB], bb [NB], bt [NB];
    int pw [N];
    int x [N], gold [N], mem [N];

    // Per-run observations
    int trace_err, first_err_cyc, gold_err;
    int done_cnt, done_cyc, busy_low_cyc, na, nb, gap_min, gap_max;
    int f_rd [8], f_ra [8], f_wr [8], f_wa [8], f_sel [8], f_ca [8], f_cb [8], f_tw [8];
    int s1_a, s1_b, s1_tw, s8_a, s8_b, s8_tw;
    int end_busy, end_rd, end_ra;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 5);
    endfunction

    function automatic int modpow(input int b, input int e);
        longint r = 1, bb2 = b;
        int ee = e;
        while (ee > 0) begin
            if (ee[0]) r = (r * bb2) % P;
            bb2 = (bb2 * bb2) % P;
            ee = ee >> 1;
        end
        return int'(r);
    endfunction

    function automatic int bitrev9(input int v);
        int r = 0;
        for (int i = 0; i < 9; i++) if (v[i]) r = r | (1 << (8 - i));
        return r;
    endfunction

    function automatic logic [36:0] outs(input int d);
        return {busy[d], done[d], rd_en[d], rd_addr[d], wr_en[d], wr_addr[d], wr_sel[d],
                cap_a[d], cap_b[d], tw[d], stage[d]};
    endfunction

    // Butterfly list by classic nested loops: stage, group start, offset in group.
    task automatic build_tables();
        int idx = 0;
        int g = 2;
        int w;
        for (int s = 0; s < 9; s++) begin
            int half = 1 << s;
            for (int st = 0; st < N; st += 2 * half) begin
                for (int j = 0; j < half; j++) begin
                    ba[idx] = st + j;
                    bb[idx] = st + j + half;
                    bt[idx] = j * (256 / half);
                    idx++;
                end
            end
        end
        while (modpow(g, 3840) == 1 || modpow(g, 2560) == 1 || modpow(g, 1536) == 1) g++;
        w = modpow(g, 15);
        pw[0] = 1;
        for (int i = 1; i < N; i++) pw[i] = int'((longint'(pw[i-1]) * w) % P);
    endtask

    // Runs one transform on DUT d with a BRAM + butterfly model; compares every cycle
    // against the schedule derived from the butterfly list.
    task automatic run_fft(input int d, input bit hold);
        int lat, per, total, last_c;
        int rd_dat, op_a, op_b, res_a, res_b, t, capb_cyc;
        int c, b, off;
        int e_busy, e_done, e_rd, e_wr, e_ca, e_cb, e_addr, e_sel, e_tw, e_stage, chk_tw;
        int s_busy, s_done, s_rd, s_ra, s_wr, s_wa, s_sel, s_ca, s_cb, s_tw, s_stage;
        longint acc;
        lat = lat_of(d); per = 4 + lat; total = NB * per; last_c = total + 3;
        for (int n = 0; n < N; n++) x[n] = int'($urandom_range(0, P - 1));
        for (int n = 0; n < N; n++) mem[bitrev9(n)] = x[n];
        for (int k = 0; k < N; k++) begin
            acc = 0;
            for (int n = 0; n < N; n++) acc = (acc + longint'(x[n]) * pw[(n * k) % N]) % P;
            gold[k] = int'(acc);
        end
        trace_err = 0; first_err_cyc = -1; done_cnt = 0; done_cyc = -1; busy_low_cyc = -1;
        na = 0; nb = 0; gap_min = 1000000; gap_max = -1; capb_cyc = -1;
        rd_dat = 0; op_a = 0; op_b = 0; res_a = 0; res_b = 0;
        s1_a = -1; s1_b = -1; s1_tw = -1; s8_a = -1; s8_b = -1; s8_tw = -1;
        end_busy = -1; end_rd = -1; end_ra = -1;
        for (int i = 0; i < 8; i++) begin
            f_rd[i] = -1; f_ra[i] = -1; f_wr[i] = -1; f_wa[i] = -1;
            f_sel[i] = -1; f_ca[i] = -1; f_cb[i] = -1; f_tw[i] = -1;
        end
        @(negedge clk); start[d] = 1'b1;
        for (int cyc = 1; cyc <= last_c; cyc++) begin
            @(negedge clk);
            if (!hold) start[d] = 1'b0;
            s_busy = int'(busy[d]); s_done = int'(done[d]); s_rd = int'(rd_en[d]);
            s_ra = int'(rd_addr[d]); s_wr = int'(wr_en[d]); s_wa = int'(wr_addr[d]);
            s_sel = int'(wr_sel[d]); s_ca = int'(cap_a[d]); s_cb = int'(cap_b[d]);
            s_tw = int'(tw[d]); s_stage = int'(stage[d]);
            // expected schedule
            c = cyc;
            if (hold && cyc > total + 2) c = cyc - (total + 2);
            e_busy = 0; e_done = 0; e_rd = 0; e_wr = 0; e_ca = 0; e_cb = 0;
            e_addr = 0; e_sel = 0; e_tw = 0; e_stage = 0; chk_tw = 0;
            if (c >= 1 && c <= total) begin
                b = (c - 1) / per; off = (c - 1) % per;
                e_busy = 1; chk_tw = 1; e_tw = bt[b]; e_stage = b / 256;
                if (off == 0) begin e_rd = 1; e_addr = ba[b]; end
                else if (off == 1) begin e_rd = 1; e_addr = bb[b]; e_ca = 1; end
                else if (off == 2) e_cb = 1;
                else if (off == per - 2) begin e_wr = 1; e_addr = ba[b]; e_sel = 0; end
                else if (off == per - 1) begin e_wr = 1; e_addr = bb[b]; e_sel = 1; end
            end else if (c == total + 1) begin
                e_busy = 1; e_done = 1;
            end
            if (s_busy !== e_busy || s_done !== e_done || s_rd !== e_rd || s_wr !== e_wr ||
                s_ca !== e_ca || s_cb !== e_cb || (e_rd == 1 && s_ra !== e_addr) ||
                (e_wr == 1 && (s_wa !== e_addr || s_sel !== e_sel)) ||
                (chk_tw == 1 && (s_tw !== e_tw || s_stage !== e_stage))) begin
                if (trace_err == 0) first_err_cyc = cyc;
                trace_err++;
            end
            // observations
            if (cyc < 8) begin
                f_rd[cyc] = s_rd; f_ra[cyc] = s_ra; f_wr[cyc] = s_wr; f_wa[cyc] = s_wa;
                f_sel[cyc] = s_sel; f_ca[cyc] = s_ca; f_cb[cyc] = s_cb; f_tw[cyc] = s_tw;
            end
            if (cyc == 1 + 257 * per) begin s1_a = s_ra; s1_tw = s_tw; end
            if (cyc == 2 + 257 * per) s1_b = s_ra;
            if (cyc == 1 + 2303 * per) begin s8_a = s_ra; s8_tw = s_tw; end
            if (cyc == 2 + 2303 * per) s8_b = s_ra;
            if (s_done == 1) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
            if (s_busy == 0 && done_cnt > 0 && busy_low_cyc < 0) busy_low_cyc = cyc;
            if (s_wr == 1 && s_sel == 0) na++;
            if (s_wr == 1 && s_sel == 1) nb++;
            if (s_wr == 1 && s_sel == 0 && capb_cyc >= 0) begin
                if (cyc - capb_cyc < gap_min) gap_min = cyc - capb_cyc;
                if (cyc - capb_cyc > gap_max) gap_max = cyc - capb_cyc;
                capb_cyc = -1;
            end
            if (cyc == last_c) begin end_busy = s_busy; end_rd = s_rd; end_ra = s_ra; end
            // BRAM + butterfly model
            if (s_wr == 1 && s_wa >= 0 && s_wa < N) mem[s_wa] = (s_sel == 1) ? res_b : res_a;
            if (s_ca == 1) op_a = rd_dat;
            if (s_cb == 1) begin
                op_b = rd_dat;
                t = int'((longint'(op_b) * pw[s_tw & 255]) % P);
                res_a = (op_a + t) % P;
                res_b = (op_a - t + P) % P;
                capb_cyc = cyc;
            end
            rd_dat = (s_rd == 1) ? mem[s_ra] : 0;
        end
        start[d] = 1'b0;
        gold_err = 0;
        for (int k = 0; k < N; k++) if (mem[k] !== gold[k]) gold_err++;
        if (hold) begin
            rst[d] = 1'b1;
            @(negedge clk);
            rst[d] = 1'b0;
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin rst[d] = 1'b1; start[d] = 1'b0; end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (outs(d) !== 37'd0) begin
                failures++; $display("FAIL reset_outputs dut%0d: got %h expected 0", d, outs(d));
            end
        end
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (outs(d) !== 37'd0) begin
                failures++; $display("FAIL idle_outputs dut%0d: got %h expected 0", d, outs(d));
            end
        end
    endtask

    task automatic test_full_run();
        run_fft(0, 1'b0);
        checks++;
        if (f_rd[1] !== 1 || f_ra[1] !== 0) begin
            failures++; $display("FAIL c1_rd_a: rd_en=%0d addr=%0d expected 1/0", f_rd[1], f_ra[1]);
        end
        checks++;
        if (f_rd[2] !== 1 || f_ra[2] !== 1 || f_ca[2] !== 1) begin
            failures++; $display("FAIL c2_rd_b: rd_en=%0d addr=%0d cap_a=%0d expected 1/1/1", f_rd[2], f_ra[2], f_ca[2]);
        end
        checks++;
        if (f_cb[3] !== 1 || f_cb[4] !== 0) begin
            failures++; $display("FAIL c3_cap_b: c3=%0d c4=%0d expected 1/0", f_cb[3], f_cb[4]);
        end
        checks++;
        if (f_wr[5] !== 1 || f_wa[5] !== 0 || f_sel[5] !== 0) begin
            failures++; $display("FAIL c5_wr_a: en=%0d addr=%0d sel=%0d expected 1/0/0", f_wr[5], f_wa[5], f_sel[5]);
        end
        checks++;
        if (f_wr[6] !== 1 || f_wa[6] !== 1 || f_sel[6] !== 1) begin
            failures++; $display("FAIL c6_wr_b: en=%0d addr=%0d sel=%0d expected 1/1/1", f_wr[6], f_wa[6], f_sel[6]);
        end
        checks++;
        if (f_tw[1] !== 0 || f_tw[6] !== 0) begin
            failures++; $display("FAIL first_tw: c1=%0d c6=%0d expected 0", f_tw[1], f_tw[6]);
        end
        checks++;
        if (s1_a !== 1) begin failures++; $display("FAIL s1k1_a: got %0d expected 1", s1_a); end
        checks++;
        if (s1_b !== 3) begin failures++; $display("FAIL s1k1_b: got %0d expected 3", s1_b); end
        checks++;
        if (s1_tw !== 128) begin failures++; $display("FAIL s1k1_tw: got %0d expected 128", s1_tw); end
        checks++;
        if (s8_a !== 255) begin failures++; $display("FAIL s8k255_a: got %0d expected 255", s8_a); end
        checks++;
        if (s8_b !== 511) begin failures++; $display("FAIL s8k255_b: got %0d expected 511", s8_b); end
        checks++;
        if (s8_tw !== 255) begin failures++; $display("FAIL s8k255_tw: got %0d expected 255", s8_tw); end
        checks++;
        if (done_cyc !== 13825) begin failures++; $display("FAIL done_cycle: got %0d expected 13825", done_cyc); end
        checks++;
        if (done_cnt !== 1) begin failures++; $display("FAIL done_pulses: got %0d expected 1", done_cnt); end
        checks++;
        if (busy_low_cyc !== 13826) begin failures++; $display("FAIL busy_low_cycle: got %0d expected 13826", busy_low_cyc); end
        checks++;
        if (na !== 2304) begin failures++; $display("FAIL writes_a: got %0d expected 2304", na); end
        checks++;
        if (nb !== 2304) begin failures++; $display("FAIL writes_b: got %0d expected 2304", nb); end
        checks++;
        if (trace_err !== 0) begin
            failures++; $display("FAIL trace_lat2: got %0d bad cycles (first %0d) expected 0", trace_err, first_err_cyc);
        end
        checks++;
        if (gold_err !== 0) begin failures++; $display("FAIL golden_lat2: got %0d bad words expected 0", gold_err); end
    endtask

    task automatic test_hold_start();
        run_fft(0, 1'b1);
        checks++;
        if (trace_err !== 0) begin
            failures++; $display("FAIL hold_trace: got %0d bad cycles (first %0d) expected 0", trace_err, first_err_cyc);
        end
        checks++;
        if (done_cnt !== 1) begin failures++; $display("FAIL hold_done_pulses: got %0d expected 1", done_cnt); end
        checks++;
        if (busy_low_cyc !== 13826) begin failures++; $display("FAIL hold_idle_cycle: got %0d expected 13826", busy_low_cyc); end
        checks++;
        if (end_busy !== 1 || end_rd !== 1 || end_ra !== 0) begin
            failures++; $display("FAIL hold_restart: busy=%0d rd_en=%0d addr=%0d expected 1/1/0", end_busy, end_rd, end_ra);
        end
    endtask

    task automatic test_reset_mid_run();
        bit found = 1'b0;
        int bad = 0;
        @(negedge clk); start[0] = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            start[0] = 1'b0;
            if (stage[0] == 4'd3) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin failures++; $display("FAIL reach_stage3: got stage %0d expected 3", stage[0]); end
        repeat ($urandom_range(0, 200)) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (outs(0) !== 37'd0) begin failures++; $display("FAIL midrst_outputs: got %h expected 0", outs(0)); end
        rst[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done[0] !== 1'b0 || busy[0] !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", bad); end
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        checks++;
        if (busy[0] !== 1'b1 || rd_en[0] !== 1'b1 || rd_addr[0] !== 9'd0 || stage[0] !== 4'd0 || tw[0] !== 8'd0) begin
            failures++; $display("FAIL restart_c1: busy=%0d rd_en=%0d addr=%0d stage=%0d tw=%0d expected 1/1/0/0/0",
                                 busy[0], rd_en[0], rd_addr[0], stage[0], tw[0]);
        end
        @(negedge clk);
        checks++;
        if (rd_addr[0] !== 9'd1 || cap_a[0] !== 1'b1) begin
            failures++; $display("FAIL restart_c2: addr=%0d cap_a=%0d expected 1/1", rd_addr[0], cap_a[0]);
        end
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
    endtask

    task automatic test_bf_lat(input int d);
        int lat = lat_of(d);
        run_fft(d, 1'b0);
        checks++;
        if (gap_min !== lat || gap_max !== lat) begin
            failures++; $display("FAIL gap_lat%0d: min=%0d max=%0d expected %0d", lat, gap_min, gap_max, lat);
        end
        checks++;
        if (done_cyc !== NB * (4 + lat) + 1) begin
            failures++; $display("FAIL done_cycle_lat%0d: got %0d expected %0d", lat, done_cyc, NB * (4 + lat) + 1);
        end
        checks++;
        if (trace_err !== 0) begin
            failures++; $display("FAIL trace_lat%0d: got %0d bad cycles (first %0d) expected 0", lat, trace_err, first_err_cyc);
        end
        checks++;
        if (gold_err !== 0) begin failures++; $display("FAIL golden_lat%0d: got %0d bad words expected 0", lat, gold_err); end
        checks++;
        if (na !== 2304 || nb !== 2304) begin
            failures++; $display("FAIL writes_lat%0d: a=%0d b=%0d expected 2304", lat, na, nb);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin rst[d] = 1'b1; start[d] = 1'b0; end
        build_tables();
        test_reset();
        test_full_run();
        test_hold_start();
        test_reset_mid_run();
        test_bf_lat(1);
        test_bf_lat(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
